// File: rtl/fact_accel_p.sv
// fact_accel_p -- self-sequenced factorial / double-factorial accelerator.
//
// A `go` pulse in IDLE or DONE latches `n` and `step2`, then the FSM multiplies
// the running product by a down-counter once per cycle until the counter
// reaches 1 or 0. A sticky flag records any product bits lost above RES_WIDTH.
//
// Ports
//   clk     in   sole clock, rising edge
//   rst_n   in   synchronous active-low reset
//   go      in   start request, honoured in IDLE and DONE only
//   n       in   operand (N_WIDTH bits)
//   step2   in   0: n!, 1: n!!
//   bufen   in   enable for bufout
//   busy    out  high while multiplying
//   done    out  high while the result is valid
//   ovf     out  sticky overflow for the current computation
//   result  out  product register
//   bufout  out  result gated by bufen (0 when disabled)
//
// state | meaning
// IDLE  | waiting for the first go after reset
// MULT  | one multiply per cycle while cnt >= 2
// DONE  | result valid; a new go restarts immediately

module fact_accel_p #(
    parameter int N_WIDTH   = 4,
    parameter int RES_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic [N_WIDTH-1:0]   n,
    input  logic                 step2,
    input  logic                 bufen,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic [RES_WIDTH-1:0] result,
    output logic [RES_WIDTH-1:0] bufout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FULL_W = RES_WIDTH + N_WIDTH;

    state_t                 state_q;
    logic [N_WIDTH-1:0]     cnt_q;
    logic                   step2_q;
    logic [RES_WIDTH-1:0]   prod_q;
    logic                   ovf_q;
    logic                   busy_q;
    logic                   done_q;

    logic [FULL_W-1:0]      full_d;
    logic [N_WIDTH-1:0]     cnt_d;

    // Widen both operands so no product bits are lost before the overflow test.
    assign full_d = {{N_WIDTH{1'b0}}, prod_q} * {{RES_WIDTH{1'b0}}, cnt_q};

    // Only evaluated while cnt_q >= 2, so it never wraps.
    assign cnt_d  = step2_q ? (cnt_q - N_WIDTH'(2)) : (cnt_q - N_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step2_q <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        state_q <= MULT;
                        cnt_q   <= n;
                        step2_q <= step2;
                        prod_q  <= RES_WIDTH'(1);
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                MULT: begin
                    if (cnt_q <= N_WIDTH'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        prod_q  <= full_d[RES_WIDTH-1:0];
                        ovf_q   <= ovf_q | (|full_d[FULL_W-1:RES_WIDTH]);
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign result = prod_q;
    assign bufout = bufen ? prod_q : '0;

endmodule

// File: tb/tb_fact_accel_p.sv
module tb_fact_accel_p;

    localparam int NW = 4;
    localparam int RW = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          go    = 1'b0;
    logic [NW-1:0] n     = '0;
    logic          step2 = 1'b0;
    logic          bufen = 1'b0;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [RW-1:0] result;
    logic [RW-1:0] bufout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fact_accel_p #(.N_WIDTH(NW), .RES_WIDTH(RW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go),
        .n      (n),
        .step2  (step2),
        .bufen  (bufen),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .result (result),
        .bufout (bufout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact product of n, n-d, ... down to 2, in 64-bit arithmetic.
    function automatic void model(input int nn, input bit s2,
                                  output longint unsigned res, output bit ov, output int k);
        longint unsigned exact;
        int d;
        exact = 1;
        d = s2 ? 2 : 1;
        k = 0;
        for (int t = nn; t >= 2; t -= d) begin
            exact = exact * longint'(t);
            k++;
        end
        res = exact & 64'h0000_0000_FFFF_FFFF;
        ov  = (exact > 64'h0000_0000_FFFF_FFFF);
    endfunction

    // Issue a one-cycle go; scramble the operand inputs after acceptance.
    task automatic start(input int nn, input bit s2);
        go    = 1'b1;
        n     = NW'(nn);
        step2 = s2;
        tick();
        go    = 1'b0;
        n     = NW'($urandom);
        step2 = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, inout int lat);
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_no_timeout"}, 64'(lat < 40), 64'd1);
    endtask

    task automatic run(input string tag, input int nn, input bit s2);
        longint unsigned res;
        bit ov;
        int k;
        int lat;
        model(nn, s2, res, ov, k);
        start(nn, s2);
        chk({tag, "_busy_after_go"}, 64'(busy), 64'd1);
        chk({tag, "_ovf_cleared"}, 64'(ovf), 64'd0);
        lat = 0;
        wait_done(tag, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(k + 1));
        chk({tag, "_result"}, 64'(result), res);
        chk({tag, "_ovf"}, 64'(ovf), 64'(ov));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        longint unsigned res;
        bit ov;
        int k;
        int lat;
        int seen_done;
        int rn;
        bit rs;

        // Reset with bufen high
        rst_n = 1'b0;
        bufen = 1'b1;
        tick();
        tick();
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_bufout", 64'(bufout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        tick();

        // 5! and output gating
        run("f5", 5, 1'b0);
        bufen = 1'b0;
        #1;
        chk("f5_bufout_off", 64'(bufout), 64'd0);
        bufen = 1'b1;
        #1;
        chk("f5_bufout_on", 64'(bufout), 64'd120);
        tick();
        chk("f5_done_hold", 64'(done), 64'd1);
        chk("f5_result_hold", 64'(result), 64'd120);

        // Degenerate operands
        run("f0", 0, 1'b0);
        run("f1", 1, 1'b0);

        // Overflow, then restart from DONE clears it
        run("f13", 13, 1'b0);
        chk("f13_const", 64'(result), 64'd1932053504);
        run("f3_after_ovf", 3, 1'b0);

        // Double factorial
        run("df7", 7, 1'b1);
        run("df8", 8, 1'b1);

        // go pulsed during MULT is ignored
        model(10, 1'b0, res, ov, k);
        start(10, 1'b0);
        lat = 0;
        tick(); lat++;
        go = 1'b1;
        n  = NW'(2);
        tick(); lat++;
        go = 1'b0;
        wait_done("f10_ign", lat);
        chk("f10_ign_latency", 64'(lat), 64'(k + 1));
        chk("f10_ign_result", 64'(result), 64'd3628800);
        chk("f10_ign_ovf", 64'(ovf), 64'(ov));

        // Reset mid-MULT aborts
        start(10, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        chk("abort_stays_idle", 64'(seen_done), 64'd0);
        run("f4_after_abort", 4, 1'b0);

        // Randomised operands and modes against the reference
        for (int i = 0; i < 12; i++) begin
            rn = int'($urandom_range(0, 15));
            rs = 1'($urandom);
            bufen = 1'($urandom);
            run($sformatf("rnd%0d", i), rn, rs);
            model(rn, rs, res, ov, k);
            chk($sformatf("rnd%0d_bufout", i), 64'(bufout), bufen ? res : 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fact_accel_p.md
# fact_accel_p

Parametrised, self-sequenced factorial accelerator: the successor of the fixed 4-bit / 32-bit factorial datapath. It accepts an operand with a `go` pulse and iterates a down-counter and multiplier under an internal FSM. It raises `done` with the product, a sticky overflow flag and a gated output bus. A step mode selects ordinary factorial (n!) or double factorial (n!!). It sits on the same accelerator bus as the original datapath and needs no external controller sequencing.

## Interface
- N_WIDTH, 4: operand width; counter width.
- RES_WIDTH, 32: product/result width.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- go  in  1  start request; sampled only in IDLE or DONE.
- n  in  N_WIDTH  operand, latched on accepted `go`.
- step2  in  1  0: n! (decrement by 1); 1: n!! (decrement by 2); latched with `n`.
- bufen  in  1  output enable for `bufout`.
- busy  out  1  high in MULT state.
- done  out  1  high in DONE state.
- ovf  out  1  sticky overflow for the current computation.
- result  out  RES_WIDTH  product register, always visible.
- bufout  out  RES_WIDTH  `bufen ? result : 0`; combinational; no tri-state.

## Operation
- States: IDLE, MULT, DONE.
- IDLE:
  - On `go`: cnt <= n, dec <= step2 ? 2 : 1, prod <= 1, ovf <= 0, go to MULT.
  - Otherwise hold.
- MULT:
  - If cnt <= 1: go to DONE; prod is unchanged.
  - Else: full = prod * cnt, which is RES_WIDTH+N_WIDTH bits wide.
  - prod <= full[RES_WIDTH-1:0].
  - ovf <= ovf | (full[RES_WIDTH+N_WIDTH-1:RES_WIDTH] != 0).
  - cnt <= cnt - dec. Underflow cannot occur, because cnt >= 2 whenever a subtraction happens.
  - `go` is ignored in MULT.
- DONE:
  - Hold prod and ovf.
  - On `go`: start a new computation exactly as from IDLE, so done-then-restart is back-to-back with no idle cycle.
- Once set, `ovf` stays high through DONE until the next accepted `go`. The truncated low bits remain in `result`.
- n = 0 and n = 1 give result 1 with zero multiplies.
- `n`/`step2` changes after acceptance have no effect.

## Timing
- Reset (rst_n low at an edge): state IDLE, result 0, busy 0, done 0, ovf 0, cnt 0.
  - bufout is 0 if bufen = 1, and 0 regardless if bufen = 0.
- Reset mid-operation aborts immediately at that edge. There is no residual `done`.
- rst_n has priority over `go` at the same edge.
- Let edge E0 be the edge that accepts `go`, and let k be the number of multiplies:
  - k = max(n-1, 0) for n!.
  - k = floor(n/2) for n!!, with n >= 2; k = 0 for n <= 1.
- Sequence after E0:
  - busy is high after E0.
  - Edges E1..Ek perform the multiplies.
  - Edge E(k+1) enters DONE: done is high and busy low from then on.
  - Latency from E0 to done is k+1 cycles.
- `result` changes during MULT. It is only valid while `done` is high.
- A `go` held high across DONE restarts on every DONE-entry edge after the first. The bench must pulse `go`.
- bufout follows bufen combinationally, with no register stage.

## Test plan
- Reset, then bufen=1 -> result 0, bufout 0, busy 0, done 0, ovf 0 on the first edge after reset.
- n=5, step2=0, go pulse -> busy for 5 cycles; done 5 cycles after E0; result 120, ovf 0. With bufen=0, bufout 0; with bufen=1, bufout 120.
- n=0, then n=1 (step2=0) -> done 1 cycle after E0, result 1, ovf 0.
- n=13 with N_WIDTH=4, RES_WIDTH=32 -> result 1932053504 (6227020800 mod 2^32), ovf 1, done after 13 cycles. Then go with n=3 from DONE -> ovf clears on acceptance, result 6.
- n=7, step2=1 -> result 105, done 4 cycles after E0. Also n=8, step2=1 -> result 384, done 5 cycles after E0.
- Interference during n=10 (step2=0):
  - Pulse go with n=2 at the third MULT cycle -> ignored; final result 3628800.
  - Repeat the run and drive rst_n low for one edge mid-MULT -> IDLE, result 0, done never asserts.
  - A subsequent go with n=4 -> result 24.
